// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the instruction-fetch and data sides of the cache block.
// Data has priority, a starvation counter guarantees fetch progress, and RAM errors are retried a bounded number of times.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt, starve_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic [31:0]   lat_addr, lat_addr_n;
  logic [31:0]   lat_store, lat_store_n;
  logic          lat_wr, lat_wr_n;
  logic [31:0]   iload_q, iload_n;
  logic [31:0]   dload_q, dload_n;

  logic        serving, abort, done, done_i, done_d;
  logic        dreq, force_i;
  logic [31:0] rdata;

  // Completion: ACCESS, or an ERROR once the retry budget is spent.
  always_comb begin
    serving = (state != IDLE);
    abort   = serving && (ramstate == RS_ERROR) && (retry_cnt == RW'(MAX_RETRY));
    done    = serving && ((ramstate == RS_ACCESS) || abort);
    done_i  = done && (state == SERVE_I);
    done_d  = done && (state == SERVE_D);
    rdata   = abort ? ERR_WORD : ramload;
  end

  assign iwait    = !done_i;
  assign dwait    = !done_d;
  assign iload    = done_i ? rdata : iload_q;
  assign dload    = (done_d && !lat_wr) ? rdata : dload_q;
  assign ramREN   = serving && !lat_wr;
  assign ramWEN   = serving && lat_wr;
  assign ramaddr  = lat_addr;
  assign ramstore = lat_store;
  assign bus_err  = abort;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_n     = state;
    starve_n    = starve_cnt;
    retry_n     = retry_cnt;
    lat_addr_n  = lat_addr;
    lat_store_n = lat_store;
    lat_wr_n    = lat_wr;
    iload_n     = iload_q;
    dload_n     = dload_q;
    dreq        = dREN || dWEN;
    force_i     = iREN && (starve_cnt == SW'(STARVE_LIMIT));

    case (state)
      IDLE: begin
        if (dreq && !force_i) begin
          state_n     = SERVE_D;
          lat_addr_n  = daddr;
          lat_store_n = dstore;
          lat_wr_n    = dWEN;
          if (!iREN)
            starve_n = '0;
          else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_n = starve_cnt + SW'(1);
        end else if (iREN) begin
          state_n     = SERVE_I;
          lat_addr_n  = iaddr;
          lat_store_n = '0;
          lat_wr_n    = 1'b0;
          starve_n    = '0;
        end else begin
          starve_n = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (done) begin
          state_n = IDLE;
          retry_n = '0;
          if (done_i)
            iload_n = rdata;
          else if (!lat_wr)
            dload_n = rdata;
        end else if (ramstate == RS_ERROR) begin
          retry_n = retry_cnt + RW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      retry_cnt  <= '0;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_wr     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      retry_cnt  <= retry_n;
      lat_addr   <= lat_addr_n;
      lat_store  <= lat_store_n;
      lat_wr     <= lat_wr_n;
      iload_q    <= iload_n;
      dload_q    <= dload_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int          STARVE_LIMIT = 4;
  localparam int          MAX_RETRY    = 3;
  localparam logic [31:0] ERR_WORD     = 32'hBAD1BAD1;
  localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: at most one transaction in flight, described by its owner and operands.
  bit          m_busy, m_is_d, m_wr;
  logic [31:0] m_addr, m_store, m_il, m_dl;
  int          m_errs, m_streak;
  bit          obs_idone, obs_ddone;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b, expected %b", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_wr = 0;
    m_addr = '0; m_store = '0; m_il = '0; m_dl = '0;
    m_errs = 0; m_streak = 0;
  endtask

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] ds,
                       input logic [1:0] rs, input logic [31:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    bit          e_abort, e_fin;
    logic [31:0] rv;
    #1;
    e_abort = m_busy && (ramstate == ERROR) && (m_errs == MAX_RETRY);
    e_fin   = m_busy && ((ramstate == ACCESS) || e_abort);
    rv      = e_abort ? ERR_WORD : ramload;
    chk_bit("ramREN", ramREN, m_busy && !m_wr);
    chk_bit("ramWEN", ramWEN, m_busy && m_wr);
    if (m_busy) chk("ramaddr", ramaddr, m_addr);
    if (m_busy && m_wr) chk("ramstore", ramstore, m_store);
    chk_bit("iwait", iwait, !(e_fin && !m_is_d));
    chk_bit("dwait", dwait, !(e_fin && m_is_d));
    chk("iload", iload, (e_fin && !m_is_d) ? rv : m_il);
    chk("dload", dload, (e_fin && m_is_d && !m_wr) ? rv : m_dl);
    chk_bit("bus_err", bus_err, e_abort);
    obs_idone = !iwait;
    obs_ddone = !dwait;
    @(posedge CLK);
    if (m_busy) begin
      if (e_fin) begin
        m_busy = 0;
        m_errs = 0;
        if (!m_is_d) m_il = rv;
        else if (!m_wr) m_dl = rv;
      end else if (ramstate == ERROR) begin
        m_errs++;
      end
    end else if ((dREN || dWEN) && !(iREN && m_streak == STARVE_LIMIT)) begin
      m_busy = 1; m_is_d = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
      m_streak = iREN ? ((m_streak < STARVE_LIMIT) ? m_streak + 1 : m_streak) : 0;
    end else if (iREN) begin
      m_busy = 1; m_is_d = 0; m_wr = 0; m_addr = iaddr; m_store = '0;
      m_streak = 0;
    end else begin
      m_streak = 0;
    end
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    nRST = 1'b0;
    #1;
    model_reset();
    chk_bit("rst_ramREN", ramREN, 1'b0);
    chk_bit("rst_ramWEN", ramWEN, 1'b0);
    chk_bit("rst_iwait", iwait, 1'b1);
    chk_bit("rst_dwait", dwait, 1'b1);
    chk_bit("rst_bus_err", bus_err, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int  d_before_i;
    bit  seen_i, d_after_i;
    bit  i_on, d_on, d_r, d_w;
    logic [31:0] i_a, d_a, d_s;
    int  r;

    nRST = 1'b0;
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    @(negedge CLK);
    apply_reset();

    // Single instruction read, two BUSY cycles before ACCESS.
    drive(1, 32'h40, 0, 0, '0, '0, BUSY, '0);
    step(); step(); step();
    drive(1, 32'h40, 0, 0, '0, '0, ACCESS, 32'h1234ABCD);
    step();
    chk_bit("single_done", obs_idone, 1'b1);
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    step();
    chk("single_iload_held", iload, 32'h1234ABCD);

    // Simultaneous fetch and write: data first, one IDLE, then fetch.
    drive(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, ACCESS, 32'h55);
    step();
    step();
    chk_bit("simul_d_first", obs_ddone, 1'b1);
    drive(1, 32'h44, 0, 0, '0, '0, ACCESS, 32'h55);
    step();
    step();
    chk_bit("simul_i_second", obs_idone, 1'b1);
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    step();

    // Starvation: fetch held while data requests back-to-back.
    apply_reset();
    d_before_i = 0; seen_i = 0; d_after_i = 0;
    for (int c = 0; c < 14; c++) begin
      drive(1, 32'h200, 1, 0, 32'h300 + c, '0, ACCESS, 32'h1000 + c);
      step();
      if (obs_ddone && !seen_i) d_before_i++;
      else if (obs_ddone && seen_i) d_after_i = 1;
      if (obs_idone) seen_i = 1;
    end
    chk("starve_d_grants", d_before_i, STARVE_LIMIT);
    chk_bit("starve_i_served", seen_i, 1'b1);
    chk_bit("starve_d_resumes", d_after_i, 1'b1);
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    step();

    // Three errors then ACCESS: normal completion.
    drive(0, '0, 1, 0, 32'h100, '0, FREE, '0);
    step();
    drive(0, '0, 1, 0, 32'h100, '0, ERROR, '0);
    step(); step(); step();
    drive(0, '0, 1, 0, 32'h100, '0, ACCESS, 32'hCAFE0001);
    step();
    chk_bit("retry_done", obs_ddone, 1'b1);
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    step();
    chk("retry_dload", dload, 32'hCAFE0001);

    // Four errors: abort with ERR_WORD and a bus_err pulse.
    drive(0, '0, 1, 0, 32'h104, '0, FREE, '0);
    step();
    drive(0, '0, 1, 0, 32'h104, '0, ERROR, 32'h77);
    step(); step(); step();
    #1;
    chk_bit("abort_bus_err", bus_err, 1'b1);
    step();
    chk_bit("abort_done", obs_ddone, 1'b1);
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    step();
    chk("abort_dload", dload, ERR_WORD);

    // Reset asserted in the middle of a data transaction.
    drive(0, '0, 1, 0, 32'h180, '0, BUSY, '0);
    step(); step();
    nRST = 1'b0;
    #1;
    chk_bit("midrst_ramREN", ramREN, 1'b0);
    chk_bit("midrst_ramWEN", ramWEN, 1'b0);
    chk_bit("midrst_iwait", iwait, 1'b1);
    chk_bit("midrst_dwait", dwait, 1'b1);
    model_reset();
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 5; c++) step();

    // Idle with loads populated, then twenty quiet cycles.
    drive(1, 32'h60, 0, 0, '0, '0, ACCESS, 32'h0BADF00D);
    step(); step();
    drive(0, '0, 1, 0, 32'h64, '0, ACCESS, 32'h600DF00D);
    step(); step();
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    for (int c = 0; c < 20; c++) step();
    chk("idle_iload", iload, 32'h0BADF00D);
    chk("idle_dload", dload, 32'h600DF00D);

    // Random traffic from protocol-compliant requesters and a random RAM.
    i_on = 0; d_on = 0; d_r = 0; d_w = 0; i_a = '0; d_a = '0; d_s = '0;
    for (int c = 0; c < 600; c++) begin
      logic [1:0] rs;
      if (!i_on && ($urandom_range(0, 2) == 0)) begin
        i_on = 1; i_a = $urandom;
      end
      if (!d_on && ($urandom_range(0, 2) == 0)) begin
        d_on = 1; r = $urandom_range(0, 3);
        d_r = (r != 1); d_w = (r != 0);
        d_a = $urandom; d_s = $urandom;
      end
      r  = $urandom_range(0, 9);
      rs = (r < 2) ? BUSY : (r < 3) ? FREE : (r < 5) ? ERROR : ACCESS;
      drive(i_on, i_a, d_on && d_r, d_on && d_w, d_a, d_s, rs, $urandom);
      step();
      if (obs_idone) i_on = 0;
      if (obs_ddone) d_on = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
